// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the backing-memory arbiter and the L1 caches that
// sit in front of it: FSM state encoding, response-tag constants and a
// helper that maps a finished transaction onto its response tag.
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_e;

  // Response tags seen by the L1s on data_source.
  localparam logic [1:0] DATA_SOURCE_NONE = 2'd0;
  localparam logic [1:0] DATA_SOURCE_ROM  = 2'd1;
  localparam logic [1:0] DATA_SOURCE_RAM  = 2'd2;

  // Writes carry no data back, so they are tagged NONE even though the
  // D-side owned the transaction.
  function automatic logic [1:0] resp_source(input logic side_d, input logic we);
    if (!side_d)  return DATA_SOURCE_ROM;
    else if (we)  return DATA_SOURCE_NONE;
    else          return DATA_SOURCE_RAM;
  endfunction

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// ---------------------------------------------------------------------------
// arb_starve_counter
// Counts consecutive D-side grants taken while the I-side was waiting and
// flags when the count reaches LIMIT, at which point the I-side wins ties.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   inc        in   D-side grant entered while I-side is requesting
//   clr        in   I-side grant entered, or I-side idle during arbitration
//   saturated  out  count has reached LIMIT
// ---------------------------------------------------------------------------
module arb_starve_counter #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic saturated
);

  localparam int unsigned CNT_W = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is in the sensitivity list because it is
  // asynchronous.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign saturated = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Arbitrates the L1I miss path and the L1D path onto one backing memory.
// D-side normally wins ties; after STARVE_LIMIT consecutive D-side wins with
// the I-side waiting, the I-side is served. One transaction at a time:
// IDLE -> GRANT_x (until mem_ack) -> RESP (one cycle) -> IDLE.
//
// Ports:
//   clock, reset                 clock, asynchronous active-high reset
//   i_req, i_address             I-side read request and address
//   d_req, d_we, d_address,
//   d_wdata                      D-side request, write enable, address, data
//   mem_ack, mem_rdata           backing memory completion and read data
//   mem_req, mem_we, mem_address,
//   mem_wdata                    registered request to backing memory
//   output_data                  last read result (shared by both sides)
//   data_source                  response tag, valid in RESP only
//   stall_i, stall_d             per-side hold signals (combinational)
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] output_data,
  output logic [1:0]        data_source,
  output logic              stall_i,
  output logic              stall_d
);

  arb_state_e        state_q;
  logic              side_d_q;       // owner of the current transaction
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] output_data_q;
  logic [1:0]        data_source_q;

  logic starve_sat;
  logic pick_d;
  logic pick_i;
  logic cnt_inc;
  logic cnt_clr;

  // Arbitration decision, only meaningful in IDLE.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    pick_d  = 1'b0;
    pick_i  = 1'b0;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    if (state_q == ST_IDLE) begin
      pick_d  = d_req && !(i_req && starve_sat);
      pick_i  = i_req && !pick_d;
      cnt_inc = pick_d && i_req;
      // In IDLE the counter either counts a D win over a waiting I-side or
      // clears (I-side won, or I-side is not requesting).
      cnt_clr = !cnt_inc;
    end
  end

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock     (clock),
    .reset     (reset),
    .inc       (cnt_inc),
    .clr       (cnt_clr),
    .saturated (starve_sat)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      side_d_q      <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      output_data_q <= '0;
      data_source_q <= DATA_SOURCE_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_d) begin
            state_q       <= ST_GRANT_D;
            side_d_q      <= 1'b1;
            mem_req_q     <= 1'b1;
            mem_we_q      <= d_we;
            mem_address_q <= d_address;
            mem_wdata_q   <= d_wdata;
          end else if (pick_i) begin
            state_q       <= ST_GRANT_I;
            side_d_q      <= 1'b0;
            mem_req_q     <= 1'b1;
            mem_we_q      <= 1'b0;
            mem_address_q <= i_address;
            mem_wdata_q   <= '0;
          end
        end

        ST_GRANT_I, ST_GRANT_D: begin
          // Address/data were latched on entry; requester changes are
          // ignored until the memory completes.
          if (mem_ack) begin
            state_q       <= ST_RESP;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            data_source_q <= resp_source(side_d_q, mem_we_q);
            if (!mem_we_q) output_data_q <= mem_rdata;
          end
        end

        ST_RESP: begin
          state_q       <= ST_IDLE;
          data_source_q <= DATA_SOURCE_NONE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign output_data = output_data_q;
  assign data_source = data_source_q;

  // A side is released only in the RESP cycle of its own transaction.
  assign stall_i = i_req && !((state_q == ST_RESP) && !side_d_q);
  assign stall_d = d_req && !((state_q == ST_RESP) &&  side_d_q);

endmodule
